// File: rtl/axi_defs_pkg.sv
// Shared AXI definitions: response codes, transfer sizes and lane helpers,
// used by both the host-side master and the simple slave.
package axi_defs_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_HALF  = 3'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [2:0] SIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {WI, WA, WD, WR} wr_state_e;
  typedef enum logic [1:0] {RI, RW, RD} rd_state_e;

  function automatic logic [7:0] size_strobe(input logic [2:0] size);
    logic [7:0] strb;
    case (size)
      SIZE_BYTE:  strb = 8'h01;
      SIZE_HALF:  strb = 8'h03;
      SIZE_WORD:  strb = 8'h0F;
      SIZE_DWORD: strb = 8'hFF;
      default:    strb = 8'h00;
    endcase
    return strb;
  endfunction

  function automatic logic [63:0] size_mask(input logic [2:0] size);
    logic [63:0] mask;
    case (size)
      SIZE_BYTE:  mask = 64'h0000_0000_0000_00FF;
      SIZE_HALF:  mask = 64'h0000_0000_0000_FFFF;
      SIZE_WORD:  mask = 64'h0000_0000_FFFF_FFFF;
      SIZE_DWORD: mask = 64'hFFFF_FFFF_FFFF_FFFF;
      default:    mask = 64'h0000_0000_0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/axi_slave_decode.sv
// Combinational address decode for one AXI address channel: range, size,
// alignment and length checks, plus RAM word index and byte-lane offset.
module axi_slave_decode
  import axi_defs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 512,
  parameter int          IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic [31:0]      i_addr,
  input  logic [2:0]       i_size,
  input  logic [7:0]       i_len,
  output logic [1:0]       o_resp,
  output logic [IDX_W-1:0] o_idx,
  output logic [2:0]       o_offset
);

  localparam logic [32:0] SPAN = 33'(MEM_WORDS * 8);

  logic [32:0] rel_s;
  logic        misalign_s;

  // An address below BASE_ADDR wraps to a huge 33-bit value, so one compare covers both ends.
  assign rel_s    = {1'b0, i_addr} - {1'b0, BASE_ADDR};
  assign o_idx    = rel_s[IDX_W+2:3];
  assign o_offset = i_addr[2:0];

  // alignment check per transfer size
  always_comb begin
    misalign_s = 1'b0;
    case (i_size)
      SIZE_BYTE:  misalign_s = 1'b0;
      SIZE_HALF:  misalign_s = i_addr[0];
      SIZE_WORD:  misalign_s = (i_addr[1:0] != 2'b00);
      SIZE_DWORD: misalign_s = (i_addr[2:0] != 3'b000);
      default:    misalign_s = 1'b0;
    endcase
  end

  // response priority: decode error, then slave error, then okay
  always_comb begin
    o_resp = RESP_OKAY;
    if (rel_s >= SPAN) begin
      o_resp = RESP_DECERR;
    end else if ((i_len != 8'd0) || (i_size > SIZE_DWORD) || misalign_s) begin
      o_resp = RESP_SLVERR;
    end else begin
      o_resp = RESP_OKAY;
    end
  end

endmodule

// File: rtl/simple_axi_slave.sv
// Single-beat AXI4 responder over an inferred 64-bit RAM. Sub-word data is
// low-lane justified on the bus and moved to its byte lanes internally.
module simple_axi_slave
  import axi_defs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 512,
  parameter int          RD_WAIT   = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic [7:0]  s_axi_awlen,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awlock,
  input  logic [3:0]  s_axi_awcache,
  input  logic [2:0]  s_axi_awprot,
  input  logic [3:0]  s_axi_awqos,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic [7:0]  s_axi_arlen,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arlock,
  input  logic [3:0]  s_axi_arcache,
  input  logic [2:0]  s_axi_arprot,
  input  logic [3:0]  s_axi_arqos,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast
);

  localparam int         IDX_W     = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

  logic [63:0] mem_q [MEM_WORDS];

  wr_state_e   wstate_q, wstate_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [7:0]  awlen_q, awlen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;

  rd_state_e   rstate_q, rstate_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic             aw_hs_s, w_hs_s, ar_hs_s, commit_s, capture_s, mem_we_s;
  logic [1:0]       aw_resp_s, ar_resp_s;
  logic [IDX_W-1:0] aw_idx_s, ar_idx_s;
  logic [2:0]       aw_off_s, ar_off_s;
  logic [7:0]       mem_wbe_s;
  logic [63:0]      mem_wdata_s, mem_rword_s;
  logic             unused_s;

  assign unused_s = ^{s_axi_wlast, s_axi_awburst, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                      s_axi_awqos, s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                      s_axi_arqos};

  // Readies and valids are forced low during reset so no handshake can land on that cycle.
  assign s_axi_awready = ~i_rst & ((wstate_q == WI) | (wstate_q == WD));
  assign s_axi_wready  = ~i_rst & ((wstate_q == WI) | (wstate_q == WA));
  assign s_axi_bvalid  = ~i_rst & (wstate_q == WR);
  assign s_axi_bresp   = i_rst ? RESP_OKAY : bresp_q;
  assign s_axi_arready = ~i_rst & (rstate_q == RI);
  assign s_axi_rvalid  = ~i_rst & (rstate_q == RD);
  assign s_axi_rlast   = s_axi_rvalid;
  assign s_axi_rresp   = i_rst ? RESP_OKAY : rresp_q;
  assign s_axi_rdata   = i_rst ? 64'h0 : rdata_q;

  assign aw_hs_s = s_axi_awvalid & s_axi_awready;
  assign w_hs_s  = s_axi_wvalid & s_axi_wready;
  assign ar_hs_s = s_axi_arvalid & s_axi_arready;

  // The _d fields already select the live bus value on a handshake, so decode sees the committing beat.
  assign awaddr_d = aw_hs_s ? s_axi_awaddr : awaddr_q;
  assign awsize_d = aw_hs_s ? s_axi_awsize : awsize_q;
  assign awlen_d  = aw_hs_s ? s_axi_awlen  : awlen_q;
  assign wdata_d  = w_hs_s  ? s_axi_wdata  : wdata_q;
  assign wstrb_d  = w_hs_s  ? s_axi_wstrb  : wstrb_q;
  assign araddr_d = ar_hs_s ? s_axi_araddr : araddr_q;
  assign arsize_d = ar_hs_s ? s_axi_arsize : arsize_q;
  assign arlen_d  = ar_hs_s ? s_axi_arlen  : arlen_q;

  axi_slave_decode #(.BASE_ADDR(BASE_ADDR), .MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) u_aw_decode (
    .i_addr(awaddr_d), .i_size(awsize_d), .i_len(awlen_d),
    .o_resp(aw_resp_s), .o_idx(aw_idx_s), .o_offset(aw_off_s)
  );

  axi_slave_decode #(.BASE_ADDR(BASE_ADDR), .MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) u_ar_decode (
    .i_addr(araddr_d), .i_size(arsize_d), .i_len(arlen_d),
    .o_resp(ar_resp_s), .o_idx(ar_idx_s), .o_offset(ar_off_s)
  );

  assign mem_we_s    = commit_s & (aw_resp_s == RESP_OKAY);
  assign mem_wbe_s   = (wstrb_d & size_strobe(awsize_d)) << aw_off_s;
  assign mem_wdata_s = wdata_d << {aw_off_s, 3'b000};
  assign mem_rword_s = mem_q[ar_idx_s];

  // write channel next state; RAM commit happens on the edge into WR
  always_comb begin
    wstate_d = wstate_q;
    bresp_d  = bresp_q;
    commit_s = 1'b0;
    case (wstate_q)
      WI: begin
        if (aw_hs_s && w_hs_s) begin
          commit_s = 1'b1;
          wstate_d = WR;
        end else if (aw_hs_s) begin
          wstate_d = WA;
        end else if (w_hs_s) begin
          wstate_d = WD;
        end else begin
          wstate_d = WI;
        end
      end
      WA: begin
        if (w_hs_s) begin
          commit_s = 1'b1;
          wstate_d = WR;
        end else begin
          wstate_d = WA;
        end
      end
      WD: begin
        if (aw_hs_s) begin
          commit_s = 1'b1;
          wstate_d = WR;
        end else begin
          wstate_d = WD;
        end
      end
      WR: begin
        if (s_axi_bready) begin
          wstate_d = WI;
        end else begin
          wstate_d = WR;
        end
      end
      default: wstate_d = WI;
    endcase
    if (commit_s) begin
      bresp_d = aw_resp_s;
    end else begin
      bresp_d = bresp_q;
    end
  end

  // read channel next state; data is captured once on entry to RD and then held
  always_comb begin
    rstate_d  = rstate_q;
    rcnt_d    = rcnt_q;
    capture_s = 1'b0;
    case (rstate_q)
      RI: begin
        if (ar_hs_s && (RD_WAIT == 0)) begin
          capture_s = 1'b1;
          rstate_d  = RD;
        end else if (ar_hs_s) begin
          rcnt_d   = 4'd0;
          rstate_d = RW;
        end else begin
          rstate_d = RI;
        end
      end
      RW: begin
        if (rcnt_q == WAIT_LAST) begin
          capture_s = 1'b1;
          rstate_d  = RD;
        end else begin
          rcnt_d   = rcnt_q + 4'd1;
          rstate_d = RW;
        end
      end
      RD: begin
        if (s_axi_rready) begin
          rstate_d = RI;
        end else begin
          rstate_d = RD;
        end
      end
      default: rstate_d = RI;
    endcase
    if (capture_s && (ar_resp_s == RESP_OKAY)) begin
      rdata_d = (mem_rword_s >> {ar_off_s, 3'b000}) & size_mask(arsize_d);
      rresp_d = ar_resp_s;
    end else if (capture_s) begin
      rdata_d = 64'h0;
      rresp_d = ar_resp_s;
    end else begin
      rdata_d = rdata_q;
      rresp_d = rresp_q;
    end
  end

  // write channel registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wstate_q <= WI;
      awaddr_q <= 32'h0;
      awsize_q <= 3'd0;
      awlen_q  <= 8'd0;
      wdata_q  <= 64'h0;
      wstrb_q  <= 8'h0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wstate_q <= wstate_d;
      awaddr_q <= awaddr_d;
      awsize_q <= awsize_d;
      awlen_q  <= awlen_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
    end
  end

  // read channel registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rstate_q <= RI;
      araddr_q <= 32'h0;
      arsize_q <= 3'd0;
      arlen_q  <= 8'd0;
      rcnt_q   <= 4'd0;
      rdata_q  <= 64'h0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      araddr_q <= araddr_d;
      arsize_q <= arsize_d;
      arlen_q  <= arlen_d;
      rcnt_q   <= rcnt_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // byte-lane RAM write; contents are intentionally left unreset
  always_ff @(posedge i_clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_wbe_s[b]) begin
          mem_q[aw_idx_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_simple_axi_slave.sv
// Scoreboard bench for simple_axi_slave (RD_WAIT = 3): drivers queue expected
// responses, B and R monitors pop and compare on each handshake.
module tb_simple_axi_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast, wlast;
  logic [31:0] awaddr, araddr;
  logic [2:0]  awsize, arsize;
  logic [7:0]  awlen, arlen, wstrb;
  logic [63:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [1:0] exp_b_q[$];
  rexp_t      exp_r_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  simple_axi_slave #(.BASE_ADDR(32'h0000_0000), .MEM_WORDS(512), .RD_WAIT(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
    .s_axi_awsize(awsize), .s_axi_awlen(awlen), .s_axi_awburst(2'b01),
    .s_axi_awlock(1'b0), .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awqos(4'h0),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
    .s_axi_arsize(arsize), .s_axi_arlen(arlen), .s_axi_arburst(2'b01),
    .s_axi_arlock(1'b0), .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arqos(4'h0),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp), .s_axi_rlast(rlast)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // B monitor
  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (exp_b_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected: got bresp 0x%0h with nothing expected", bresp);
      end else begin
        check("bresp", 64'(bresp), 64'(exp_b_q.pop_front()));
      end
    end
  end

  // R monitor
  always @(negedge clk) begin
    rexp_t e;
    if (!rst && rvalid && rready) begin
      if (exp_r_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL r_unexpected: got rdata 0x%0h with nothing expected", rdata);
      end else begin
        e = exp_r_q.pop_front();
        check("rdata", rdata, e.data);
        check("rresp", 64'(rresp), 64'(e.resp));
        check("rlast", 64'(rlast), 64'd1);
      end
    end
  end

  // Tasks start and end 1 time unit after a rising edge.
  task automatic send(input bit do_aw, input bit do_w, input bit do_ar, input logic [31:0] addr,
                      input logic [2:0] size, input logic [7:0] len, input logic [63:0] wd,
                      input logic [7:0] ws);
    int n;
    n = 0;
    if (do_aw) begin awaddr = addr; awsize = size; awlen = len; awvalid = 1'b1; end
    if (do_w)  begin wdata = wd; wstrb = ws; wvalid = 1'b1; end
    if (do_ar) begin araddr = addr; arsize = size; arlen = len; arvalid = 1'b1; end
    @(negedge clk);
    while (((do_aw && !awready) || (do_w && !wready) || (do_ar && !arready)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake_timeout: got no ready after %0d cycles, addr 0x%0h", n, addr);
    end
    @(posedge clk);
    #1;
    if (do_aw) awvalid = 1'b0;
    if (do_w)  wvalid  = 1'b0;
    if (do_ar) arvalid = 1'b0;
  endtask

  task automatic wait_b();
    int lat;
    lat = 1;
    @(negedge clk);
    while (!bvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("b_latency", 64'(lat), 64'd1);
    check("no_accept_in_wr", 64'({awready, wready}), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // mode 0: AW+W together, 1: W first, 2: AW first; gap = cycles between the two handshakes
  task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                          input logic [63:0] d, input logic [7:0] s, input int mode,
                          input int gap, input logic [1:0] exp_resp);
    exp_b_q.push_back(exp_resp);
    if (mode == 0) begin
      send(1'b1, 1'b1, 1'b0, addr, size, len, d, s);
    end else begin
      send(mode == 2, mode == 1, 1'b0, addr, size, len, d, s);
      @(negedge clk);
      check(mode == 1 ? "wd_readies" : "wa_readies", 64'({awready, wready}),
            mode == 1 ? 64'd2 : 64'd1);
      repeat (gap - 1) @(posedge clk);
      #1;
      send(mode == 1, mode == 2, 1'b0, addr, size, len, d, s);
    end
    wait_b();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                         input logic [63:0] exp_data, input logic [1:0] exp_resp, input int hold);
    int lat;
    exp_r_q.push_back('{data: exp_data, resp: exp_resp});
    if (hold > 0) rready = 1'b0;
    send(1'b0, 1'b0, 1'b1, addr, size, len, 64'h0, 8'h0);
    lat = 1;
    @(negedge clk);
    while (!rvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("r_latency", 64'(lat), 64'd4);
    for (int i = 0; i < hold; i++) begin
      check("r_hold_valid", 64'(rvalid), 64'd1);
      check("r_hold_data", rdata, exp_data);
      @(posedge clk);
      #1;
      if (i == hold - 1) rready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1; wlast = 1'b1;
    awaddr = 32'h0; araddr = 32'h0; awsize = 3'd0; arsize = 3'd0; awlen = 8'd0; arlen = 8'd0;
    wdata = 64'h0; wstrb = 8'h0;

    @(negedge clk);
    check("rst_handshake_outs", 64'({awready, wready, bvalid, arready, rvalid, rlast}), 64'd0);
    check("rst_data_outs", {bresp, rresp, rdata[59:0]}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_readies", 64'({awready, wready, arready, bvalid, rvalid}), 64'b11100);
    @(posedge clk);
    #1;

    // basic dword and byte accesses
    do_write(32'h10, 3'd3, 8'd0, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 2'd0);
    do_read(32'h10, 3'd3, 8'd0, 64'h1122_3344_5566_7788, 2'd0, 0);
    do_write(32'h13, 3'd0, 8'd0, 64'h0000_0000_0000_00AB, 8'h01, 0, 0, 2'd0);
    do_read(32'h10, 3'd3, 8'd0, 64'h1122_3344_AB66_7788, 2'd0, 0);
    do_read(32'h13, 3'd0, 8'd0, 64'h0000_0000_0000_00AB, 2'd0, 0);

    // split channel ordering
    do_write(32'h20, 3'd3, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 2'd0);
    do_write(32'h22, 3'd1, 8'd0, 64'h0000_0000_0000_BEEF, 8'h03, 1, 3, 2'd0);
    do_write(32'h24, 3'd2, 8'd0, 64'h0000_0000_1234_5678, 8'h0F, 2, 2, 2'd0);
    do_read(32'h20, 3'd3, 8'd0, 64'h1234_5678_BEEF_CDEF, 2'd0, 0);
    do_read(32'h24, 3'd2, 8'd0, 64'h0000_0000_1234_5678, 2'd0, 0);

    // error responses and their priority
    do_write(32'h1000, 3'd3, 8'd0, 64'hDEAD, 8'hFF, 0, 0, 2'd3);
    do_write(32'h1001, 3'd1, 8'd0, 64'hDEAD, 8'h03, 0, 0, 2'd3);
    do_write(32'h21, 3'd1, 8'd0, 64'h0000_0000_0000_FFFF, 8'h03, 0, 0, 2'd2);
    do_write(32'h20, 3'd4, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 2'd2);
    do_write(32'h20, 3'd3, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 2'd2);
    do_read(32'h20, 3'd3, 8'd0, 64'h1234_5678_BEEF_CDEF, 2'd0, 0);
    do_read(32'h20, 3'd3, 8'd1, 64'h0, 2'd2, 0);
    do_read(32'h1000, 3'd3, 8'd0, 64'h0, 2'd3, 0);
    do_read(32'h22, 3'd2, 8'd0, 64'h0, 2'd2, 0);

    // wait states, rready back-pressure and concurrent same-word writes
    do_write(32'h40, 3'd3, 8'd0, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 0, 0, 2'd0);
    fork
      do_read(32'h40, 3'd3, 8'd0, 64'hAAAA_AAAA_AAAA_AAAA, 2'd0, 4);
      begin
        repeat (3) @(posedge clk);
        #1;
        do_write(32'h40, 3'd3, 8'd0, 64'h5555_5555_5555_5555, 8'hFF, 0, 0, 2'd0);
      end
    join
    do_read(32'h40, 3'd3, 8'd0, 64'h5555_5555_5555_5555, 2'd0, 0);
    fork
      do_read(32'h40, 3'd3, 8'd0, 64'h6666_6666_6666_6666, 2'd0, 0);
      begin
        @(posedge clk);
        #1;
        do_write(32'h40, 3'd3, 8'd0, 64'h6666_6666_6666_6666, 8'hFF, 0, 0, 2'd0);
      end
    join

    // reset in the middle of WA and RW
    send(1'b1, 1'b0, 1'b0, 32'h18, 3'd3, 8'd0, 64'h0, 8'h0);
    send(1'b0, 1'b0, 1'b1, 32'h10, 3'd3, 8'd0, 64'h0, 8'h0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outs", 64'({awready, wready, bvalid, arready, rvalid}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_idle", 64'({awready, wready, arready, bvalid, rvalid}), 64'b11100);
    @(posedge clk);
    #1;
    do_write(32'h18, 3'd3, 8'd0, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 0, 0, 2'd0);
    do_read(32'h18, 3'd3, 8'd0, 64'hCAFE_F00D_DEAD_BEEF, 2'd0, 0);
    do_read(32'h10, 3'd3, 8'd0, 64'h1122_3344_AB66_7788, 2'd0, 0);

    repeat (5) @(posedge clk);
    check("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
    check("r_queue_drained", 64'(exp_r_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_axi_slave.md
Name: simple_axi_slave

Overview:
Single-beat AXI4 responder backed by an internal 64-bit-wide RAM. It is the counterpart to the team's host-side AXI master and serves as the bench memory model and as on-chip scratch RAM. Write and read channels run independently. Sub-word data is low-lane justified on the bus: byte/half/word payloads sit in bits [7:0]/[15:0]/[31:0] regardless of address, and the slave shifts them to the correct lanes internally.

Parameters:
BASE_ADDR, 32'h0000_0000, first decoded byte address (8-byte aligned)
MEM_WORDS, 512, RAM depth in 64-bit words (power of 2)
RD_WAIT, 0, extra cycles between AR acceptance and rvalid (0..15)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_awaddr  in  32  write byte address
s_axi_awsize  in  3  write size, 0..3
s_axi_awlen  in  8  burst length; only 0 is legal
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_wdata  in  64  low-lane-justified write data
s_axi_wstrb  in  8  low-lane-justified strobes
s_axi_wlast  in  1  ignored
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_bresp  out  2  write response
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_araddr  in  32  read byte address
s_axi_arsize  in  3  read size
s_axi_arlen  in  8  burst length; only 0 is legal
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
s_axi_rdata  out  64  low-lane-justified read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  equals rvalid
burst/cache/prot/lock/qos inputs  in  various  accepted and ignored

Behaviour:
- Reset: all valid/ready outputs 0 on the reset cycle, bresp/rresp = 0, rdata = 0, both FSMs idle. RAM contents are not reset.
- Write FSM states:
  - WI (awready = wready = 1): AW only -> WA; W only -> WD; both -> WR.
  - WA (awready = 0, wready = 1): W handshake -> WR.
  - WD (awready = 1, wready = 0): AW handshake -> WR.
  - WR (bvalid = 1): bready -> WI.
- AW and W fields are latched on their handshakes.
- RAM commit happens on the WI/WA/WD -> WR edge. bvalid rises the next cycle, so minimum AW+W-to-bvalid latency is 1 cycle.
- bresp priority:
  - DECERR (3) if the address is outside [BASE_ADDR, BASE_ADDR + 8*MEM_WORDS).
  - else SLVERR (2) if awlen != 0, or awsize > 3, or the address is misaligned for its size.
  - else OKAY (0).
  - No RAM write on any error.
- Lane mapping: let o = addr[2:0] and idx = (addr - BASE_ADDR) >> 3.
  - Write: effective strobe = (wstrb & size_strobe) << o; data << 8*o.
  - size_strobe values: 0x01 / 0x03 / 0x0F / 0xFF.
  - Bytes whose effective strobe bit is 0 are unchanged.
- Read FSM states:
  - RI (arready = 1): handshake latches AR; go to RW if RD_WAIT > 0, else RD.
  - RW: counter counts RD_WAIT cycles, then -> RD.
  - RD (rvalid = rlast = 1): rready -> RI.
- rdata and rresp are captured on entry to RD and held stable while rvalid && !rready.
- rdata = (word >> 8*o) & size_mask. rresp uses the same rules and priority as bresp. rdata = 0 on error.
- Same-word read capture and write commit on the same edge: the read returns the old data.
- Read-after-write visibility is guaranteed only once bvalid has been observed.
- rvalid and bvalid, once asserted, stay high until their ready (AXI rule).

Decomposition:
- Shared package axi_defs_pkg holds RESP_OKAY/EXOKAY/SLVERR/DECERR, SIZE_BYTE..DWORD, and size_strobe/size_mask functions. These are also used by the master.
- One sub-module, axi_slave_decode: combinational address-range, alignment and len check producing resp[1:0], idx, and lane offset. It is instantiated twice, once for AW and once for AR.
- RAM is inferred inline.

Test Plan:
1. Write dword 0x1122334455667788 at 0x10 (AW and W same cycle) -> bvalid after 1 cycle, bresp = 0. Read 0x10 size 3 -> rdata = 0x1122334455667788, rresp = 0.
2. After test 1, write byte 0xAB (wdata = 0xAB, wstrb = 0x01) at 0x13 -> bresp = 0. Dword read at 0x10 -> 0x11223344AB667788. Byte read at 0x13 -> 0x00000000000000AB.
3. W arrives 3 cycles before AW, then AW; separately, AW arrives before W -> each gives exactly one bvalid, correct commit, no second handshake accepted while in WR.
4. Errors:
   - Write to BASE_ADDR + 8*MEM_WORDS -> bresp = 3.
   - Half write at 0x21 -> bresp = 2, RAM word unchanged.
   - Read with arlen = 1 -> rresp = 2, rdata = 0.
5. RD_WAIT = 3, rready held low 4 cycles -> rvalid rises 4 cycles after AR handshake; rdata stable until rready. Concurrent write to the same word during the wait completes with bresp = 0.
6. Assert i_rst while in WA and RW -> next cycle all valids are 0, FSMs idle. A fresh write/read then completes normally.
